// File: rtl/ttl_univ_shift_reg.sv
// 74194-class universal shift register emulated in the mclk domain: sampled device clock,
// delayed data/mode inputs, filtered clear. Optional TTL_SHIFT_CLK_DEGLITCH_EN adds a 2-sample clk qualifier.
module ttl_univ_shift_reg #(
    parameter int WIDTH    = 4,
    parameter int DLY      = 2,
    parameter int CLR_FILT = 2
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             clk,
    input  logic             clr_n,
    input  logic [1:0]       s,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    localparam int BW = WIDTH + 4;
    localparam int CW = $clog2(CLR_FILT + 1);

    logic [BW-1:0]    in_bus;
    logic [BW-1:0]    dly_bus;
    logic [1:0]       s_dly;
    logic             sr_dly;
    logic             sl_dly;
    logic [WIDTH-1:0] d_dly;

    assign in_bus = {s, sr_in, sl_in, d};

    generate
        if (DLY == 0) begin : g_nodly
            assign dly_bus = in_bus;
        end else begin : g_dly
            logic [BW-1:0] pipe_reg [DLY];

            always_ff @(posedge mclk) begin
                if (!rst_n) begin
                    pipe_reg[0] <= '0;
                end else begin
                    pipe_reg[0] <= in_bus;
                end
            end

            for (genvar gi = 1; gi < DLY; gi++) begin : g_stage
                always_ff @(posedge mclk) begin
                    if (!rst_n) begin
                        pipe_reg[gi] <= '0;
                    end else begin
                        pipe_reg[gi] <= pipe_reg[gi-1];
                    end
                end
            end

            assign dly_bus = pipe_reg[DLY-1];
        end
    endgenerate

    assign s_dly  = dly_bus[BW-1 -: 2];
    assign sr_dly = dly_bus[WIDTH+1];
    assign sl_dly = dly_bus[WIDTH];
    assign d_dly  = dly_bus[WIDTH-1:0];

    // Clear filter counts the current sample too, so the clear bites on the CLR_FILT-th low sample.
    logic [CW-1:0] clr_cnt_reg;
    logic [CW-1:0] clr_cnt_next;
    logic          clr_eff;

    always_comb begin
        clr_cnt_next = '0;
        if (!clr_n) begin
            if (clr_cnt_reg >= CW'(CLR_FILT)) begin
                clr_cnt_next = clr_cnt_reg;
            end else begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
            end
        end
    end

    assign clr_eff = (clr_cnt_next >= CW'(CLR_FILT));

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            clr_cnt_reg <= '0;
        end else begin
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // History resets high so a clk already high after reset is not seen as a rise.
    logic clk_prev_reg;
    logic clk_rise;

`ifdef TTL_SHIFT_CLK_DEGLITCH_EN
    logic clk_prev2_reg;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            clk_prev_reg  <= 1'b1;
            clk_prev2_reg <= 1'b1;
        end else begin
            clk_prev_reg  <= clk;
            clk_prev2_reg <= clk_prev_reg;
        end
    end

    assign clk_rise = clk & clk_prev_reg & ~clk_prev2_reg;
`else
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= clk;
        end
    end

    assign clk_rise = clk & ~clk_prev_reg;
`endif

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_n_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lo
                assign shr_val[gi] = sr_dly;
            end else begin : g_lo_n
                assign shr_val[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_hi
                assign shl_val[gi] = sl_dly;
            end else begin : g_hi_n
                assign shl_val[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (clr_eff) begin
            q_next = '0;
        end else if (clk_rise) begin
            case (s_dly)
                2'b01:   q_next = shr_val;
                2'b10:   q_next = shl_val;
                2'b11:   q_next = d_dly;
                default: q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            q_reg   <= '0;
            q_n_reg <= '1;
        end else begin
            q_reg   <= q_next;
            q_n_reg <= ~q_next;
        end
    end

    assign q   = q_reg;
    assign q_n = q_n_reg;

endmodule

// File: tb/tb_ttl_univ_shift_reg.sv
// Scoreboard bench for ttl_univ_shift_reg: two instances (DLY=2/CLR_FILT=2 and DLY=0/CLR_FILT=3)
// checked every mclk against a sample-history reference model.
module tb_ttl_univ_shift_reg;

    localparam int W = 4;

    logic         mclk = 1'b0;
    logic         rst_n;
    logic         clk;
    logic         clr_n;
    logic [1:0]   s;
    logic         sr_in;
    logic         sl_in;
    logic [W-1:0] d;
    logic [W-1:0] q0, qn0, q1, qn1;

    always #5 mclk = ~mclk;

    ttl_univ_shift_reg #(.WIDTH(W), .DLY(2), .CLR_FILT(2)) dut0 (
        .mclk(mclk), .rst_n(rst_n), .clk(clk), .clr_n(clr_n), .s(s),
        .sr_in(sr_in), .sl_in(sl_in), .d(d), .q(q0), .q_n(qn0)
    );

    ttl_univ_shift_reg #(.WIDTH(W), .DLY(0), .CLR_FILT(3)) dut1 (
        .mclk(mclk), .rst_n(rst_n), .clk(clk), .clr_n(clr_n), .s(s),
        .sr_in(sr_in), .sl_in(sl_in), .d(d), .q(q1), .q_n(qn1)
    );

    typedef struct packed {
        logic         clk;
        logic         clr_n;
        logic [1:0]   s;
        logic         sr;
        logic         sl;
        logic [W-1:0] d;
    } samp_t;

    // Model state: samples taken at each posedge since the last reset (newest at the back).
    samp_t        hist[$];
    int           since_rst = 0;
    logic [W-1:0] qm0 = '0;
    logic [W-1:0] qm1 = '0;
    logic [W-1:0] sb0[$];
    logic [W-1:0] sb1[$];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic samp_t samp_back(input int j);
        samp_t z;
        z = '0;
        if (j < since_rst) z = hist[hist.size() - 1 - j];
        return z;
    endfunction

    function automatic logic clk_back(input int j);
        samp_t t;
        if (j >= since_rst) return 1'b1;
        t = hist[hist.size() - 1 - j];
        return t.clk;
    endfunction

    function automatic logic [W-1:0] next_q(input logic [W-1:0] cur, input int dly, input int filt);
        bit    all_low;
        bit    rise;
        samp_t sd;
        samp_t t;
        all_low = 1'b1;
        for (int j = 0; j < filt; j++) begin
            t = samp_back(j);
            if (j >= since_rst || t.clr_n) all_low = 1'b0;
        end
        if (all_low) return '0;
`ifdef TTL_SHIFT_CLK_DEGLITCH_EN
        rise = clk_back(0) && clk_back(1) && !clk_back(2);
`else
        rise = clk_back(0) && !clk_back(1);
`endif
        if (!rise) return cur;
        sd = samp_back(dly);
        case (sd.s)
            2'd1:    return (cur << 1) | W'(sd.sr);
            2'd2:    return (cur >> 1) | (W'(sd.sl) << (W - 1));
            2'd3:    return sd.d;
            default: return cur;
        endcase
    endfunction

    // Predict the state after the upcoming posedge from the current inputs, then wait past it.
    task automatic tick();
        samp_t cur;
        cur = '{clk: clk, clr_n: clr_n, s: s, sr: sr_in, sl: sl_in, d: d};
        if (!rst_n) begin
            hist.delete();
            since_rst = 0;
            qm0 = '0;
            qm1 = '0;
        end else begin
            hist.push_back(cur);
            if (hist.size() > 8) void'(hist.pop_front());
            if (since_rst < 1000) since_rst++;
            qm0 = next_q(qm0, 2, 2);
            qm1 = next_q(qm1, 0, 3);
        end
        sb0.push_back(qm0);
        sb1.push_back(qm1);
        @(negedge mclk);
    endtask

    task automatic drive(input logic r, input logic c, input logic cl, input logic [1:0] sv,
                         input logic srv, input logic slv, input logic [W-1:0] dv, input int n);
        rst_n = r; clk = c; clr_n = cl; s = sv; sr_in = srv; sl_in = slv; d = dv;
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end else begin
            $display("ok   %s t=%0t q=%h", name, $time, act);
        end
    endtask

    // Monitor: one expected value per instance per mclk, compared just after the edge.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge mclk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                check("q_dly2", q0, e);
                check("qn_dly2", qn0, ~e);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check("q_dly0", q1, e);
                check("qn_dly0", qn1, ~e);
            end
        end
    end

    initial begin
        int burst;
        burst = 0;
        // Reset with clk high, then release with clk still high: no false edge.
        drive(0, 1, 1, 2'd3, 0, 0, 4'hF, 2);
        drive(1, 1, 1, 2'd3, 0, 0, 4'hF, 3);
        // Parallel load A, then clk held high.
        drive(1, 0, 1, 2'd3, 0, 0, 4'hA, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'hA, 6);
        // Load 0, then four shift-right rises with sr_in=1.
        drive(1, 0, 1, 2'd3, 0, 0, 4'h0, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'h0, 2);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2'd1, 1, 0, 4'h0, 3);
            drive(1, 1, 1, 2'd1, 1, 0, 4'h0, 1);
        end
        // Load 8, then four shift-left rises with sl_in=0.
        drive(1, 0, 1, 2'd3, 0, 0, 4'h8, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'h8, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2'd2, 0, 0, 4'h8, 3);
            drive(1, 1, 1, 2'd2, 0, 0, 4'h8, 1);
        end
        // Load A, glitch on clr_n, then a real clear with a rise buried inside it.
        drive(1, 0, 1, 2'd3, 0, 0, 4'hA, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'hA, 2);
        drive(1, 1, 0, 2'd3, 0, 0, 4'hA, 1);
        drive(1, 0, 1, 2'd3, 0, 0, 4'hF, 3);
        drive(1, 0, 0, 2'd3, 0, 0, 4'hF, 2);
        drive(1, 1, 0, 2'd3, 0, 0, 4'hF, 2);
        drive(1, 1, 1, 2'd3, 0, 0, 4'hF, 3);
        // Data changes on the same mclk as the clk rise.
        drive(1, 0, 1, 2'd3, 0, 0, 4'h3, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'hC, 1);
        drive(1, 1, 1, 2'd3, 0, 0, 4'hC, 3);
        // Single-sample clk pulse, then a two-sample pulse with d=6.
        drive(1, 0, 1, 2'd3, 0, 0, 4'h6, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'h6, 1);
        drive(1, 0, 1, 2'd3, 0, 0, 4'h6, 3);
        drive(1, 1, 1, 2'd3, 0, 0, 4'h6, 2);
        drive(1, 0, 1, 2'd3, 0, 0, 4'h6, 2);
        // Alternating clk every mclk with shift right.
        for (int i = 0; i < 6; i++) drive(1, i[0], 1, 2'd1, i[1], 0, 4'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) clk = ~clk;
            if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(1, 5);
            clr_n = (burst == 0);
            if (burst > 0) burst--;
            if ($urandom_range(0, 3) == 0) s = 2'($urandom_range(0, 3));
            sr_in = 1'($urandom_range(0, 1));
            sl_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) d = W'($urandom_range(0, 15));
            tick();
        end

        @(posedge mclk);
        #3;
        n_cmp++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
